// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB master bridge and its timeout counter.
//  - Default bus widths and the default timeout length.
//  - FSM state encoding: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
//  - Width of the ACCESS-cycle timeout counter.
package apb_master_bridge_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
    localparam int unsigned CNT_WIDTH          = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase timeout counter for the APB master bridge.
// Ports:
//  clk      in   rising-edge clock
//  rst      in   asynchronous reset, active high
//  clear    in   zero the count (asserted while in SETUP, i.e. on entry to ACCESS)
//  enable   in   count this cycle (ACCESS with pready low)
//  reached  out  this enabled cycle is the LIMIT-th one without pready
module apb_timeout_cnt
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic reached
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LIMIT - 1);

    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Flag is combinational so the FSM can leave ACCESS at the end of the
    // very cycle in which the count would hit LIMIT.
    assign reached = enable && (count_reg == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: accepts single read/write commands, runs one APB transfer
// per command, and returns read data plus error/timeout status.
// Ports:
//  clk, rst                          clock, asynchronous active-high reset
//  cmd_valid/cmd_ready               command handshake (ready only in IDLE)
//  cmd_write, cmd_addr, cmd_wdata    command fields, latched at acceptance
//  rsp_valid                         one-cycle completion pulse
//  rsp_rdata, rsp_err, rsp_timeout   response, held until the next rsp_valid
//  psel, penable, pwrite, paddr,
//  pwdata                            APB request outputs (all registered)
//  prdata, pready, pslverr           APB slave responses
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    apb_state_t            state_reg,       state_next;
    logic                  cmd_ready_reg,   cmd_ready_next;
    logic                  psel_reg,        psel_next;
    logic                  penable_reg,     penable_next;
    logic                  pwrite_reg,      pwrite_next;
    logic [ADDR_WIDTH-1:0] paddr_reg,       paddr_next;
    logic [DATA_WIDTH-1:0] pwdata_reg,      pwdata_next;
    logic                  rsp_valid_reg,   rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg,   rsp_rdata_next;
    logic                  rsp_err_reg,     rsp_err_next;
    logic                  rsp_timeout_reg, rsp_timeout_next;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_reached;

    // SETUP always lasts one cycle, so clearing there zeroes the counter
    // exactly on entry to ACCESS.
    assign cnt_clear  = (state_reg == ST_SETUP);
    assign cnt_enable = (state_reg == ST_ACCESS) && !pready;

    apb_timeout_cnt #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .reached (cnt_reached)
    );

    always_comb begin
        state_next       = state_reg;
        cmd_ready_next   = cmd_ready_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        pwrite_next      = pwrite_reg;
        paddr_next       = paddr_reg;
        pwdata_next      = pwdata_reg;
        rsp_valid_next   = 1'b0;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    state_next     = ST_SETUP;
                    cmd_ready_next = 1'b0;
                    psel_next      = 1'b1;
                    penable_next   = 1'b0;
                    pwrite_next    = cmd_write;
                    paddr_next     = cmd_addr;
                    pwdata_next    = cmd_write ? cmd_wdata : '0;
                end
            end
            ST_SETUP: begin
                state_next   = ST_ACCESS;
                penable_next = 1'b1;
            end
            ST_ACCESS: begin
                // pready is tested first so a ready in the limit cycle
                // still completes the transfer normally.
                if (pready) begin
                    state_next       = ST_IDLE;
                    cmd_ready_next   = 1'b1;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = pwrite_reg ? '0 : prdata;
                    rsp_err_next     = pslverr;
                    rsp_timeout_next = 1'b0;
                end else if (cnt_reached) begin
                    state_next       = ST_IDLE;
                    cmd_ready_next   = 1'b1;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = '0;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                cmd_ready_next = 1'b1;
                psel_next      = 1'b0;
                penable_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cmd_ready_reg   <= 1'b1;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cmd_ready_reg   <= cmd_ready_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            pwrite_reg      <= pwrite_next;
            paddr_reg       <= paddr_next;
            pwdata_reg      <= pwdata_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign psel        = psel_reg;
    assign penable     = penable_reg;
    assign pwrite      = pwrite_reg;
    assign paddr       = paddr_reg;
    assign pwdata      = pwdata_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge with a small APB slave model.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    // ---------------- counters and checker ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---------------- APB slave model ----------------
    // 16-word memory at paddr[5:2]; any address with bit 8 set errors.
    // pready rises after slave_wait ACCESS cycles without ready.
    logic [31:0] smem [0:15];
    logic [7:0]  slave_wait;
    int          acc_cnt;

    assign pready  = psel && penable && (acc_cnt >= int'(slave_wait));
    assign pslverr = psel && penable && paddr[8];
    assign prdata  = smem[paddr[5:2]];

    always @(posedge clk) begin
        if (rst) begin
            acc_cnt <= 0;
            for (int i = 0; i < 16; i++) smem[i] <= 32'hA500_0000 | 32'(i);
        end else begin
            if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
            else                            acc_cnt <= 0;
            if (psel && penable && pready && pwrite && !paddr[8])
                smem[paddr[5:2]] <= pwdata;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [0:15];
    int          cyc = 0;
    logic [31:0] exp_paddr;
    logic        exp_pwrite;
    logic [31:0] exp_pwdata;
    logic [31:0] held_rdata;
    logic        held_err;
    logic        held_to;
    logic        prev_psel;
    int          n_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Response and bus monitor, sampled on the falling edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            prev_psel  <= 1'b0;
            held_rdata <= '0;
            held_err   <= 1'b0;
            held_to    <= 1'b0;
        end else begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
                    chk("rsp_err",     64'(rsp_err),     64'(e.err));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                    chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                    held_rdata <= e.rdata;
                    held_err   <= e.err;
                    held_to    <= e.to;
                    n_rsp++;
                    $display("rsp %0d: rdata=%h err=%0d timeout=%0d latency=%0d",
                             n_rsp, rsp_rdata, rsp_err, rsp_timeout, cyc - e.acc_cyc);
                end
            end else begin
                chk("hold_rdata",   64'(rsp_rdata),   64'(held_rdata));
                chk("hold_err",     64'(rsp_err),     64'(held_err));
                chk("hold_timeout", 64'(rsp_timeout), 64'(held_to));
            end
            if (psel) begin
                chk("bus_paddr",   64'(paddr),   64'(exp_paddr));
                chk("bus_pwrite",  64'(pwrite),  64'(exp_pwrite));
                chk("bus_pwdata",  64'(pwdata),  64'(exp_pwdata));
                chk("bus_penable", 64'(penable), 64'(prev_psel));
                chk("bus_cmd_ready_busy", 64'(cmd_ready), 64'(0));
            end else begin
                chk("idle_penable", 64'(penable), 64'(0));
                chk("idle_paddr",   64'(paddr),   64'(exp_paddr));
                chk("idle_pwdata",  64'(pwdata),  64'(exp_pwdata));
            end
            prev_psel <= psel;
        end
    end

    // ---------------- driver tasks ----------------
    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [7:0] w, input bit hold, input bit b2b);
        exp_t e;
        bit   ok;
        bit   is_to;
        slave_wait = w;
        cmd_write  = wr;
        cmd_addr   = addr;
        cmd_wdata  = data;
        cmd_valid  = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("cmd_accept", 64'(0), 64'(1));
            cmd_valid = 1'b0;
            return;
        end
        if (b2b) chk("b2b_accept_with_rsp", 64'(rsp_valid), 64'(1));
        is_to     = (int'(w) >= TO);
        e.to      = is_to;
        e.err     = is_to | addr[8];
        e.rdata   = (wr || is_to) ? 32'h0 : ref_mem[addr[5:2]];
        e.acc_cyc = cyc;
        e.lat     = is_to ? TO + 2 : 3 + int'(w);
        if (wr && !is_to && !addr[8]) ref_mem[addr[5:2]] = data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        exp_paddr  = addr;
        exp_pwrite = wr;
        exp_pwdata = wr ? data : 32'h0;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rsp_wait", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        r_wr;
        logic [31:0] r_addr;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        slave_wait = 8'd0;
        exp_paddr  = '0;
        exp_pwrite = 1'b0;
        exp_pwdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_psel",      64'(psel),      64'(0));
        chk("rst_penable",   64'(penable),   64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_paddr",     64'(paddr),     64'(0));
        chk("rst_pwdata",    64'(pwdata),    64'(0));
        @(posedge clk);
        #1;

        send(1'b1, 32'h10,  32'hDEADBEEF, 8'd0,  1'b0, 1'b0); wait_done();  // write, zero wait
        send(1'b0, 32'h10,  32'h0,        8'd0,  1'b0, 1'b0); wait_done();  // read back
        send(1'b0, 32'h100, 32'h0,        8'd0,  1'b0, 1'b0); wait_done();  // pslverr read
        send(1'b0, 32'h10,  32'h0,        8'd255, 1'b0, 1'b0); wait_done(); // timeout
        send(1'b0, 32'h10,  32'h0,        8'd15, 1'b0, 1'b0); wait_done();  // ready in limit cycle
        send(1'b0, 32'h10,  32'h0,        8'd16, 1'b0, 1'b0); wait_done();  // one cycle too late
        send(1'b1, 32'h14,  32'h12345678, 8'd2,  1'b0, 1'b0); wait_done();
        send(1'b0, 32'h14,  32'h0,        8'd3,  1'b0, 1'b0); wait_done();
        send(1'b1, 32'h104, 32'h00000001, 8'd0,  1'b0, 1'b0); wait_done();  // write error
        send(1'b0, 32'h04,  32'h0,        8'd1,  1'b0, 1'b0); wait_done();  // untouched by it

        // back-to-back with cmd_valid held across the first transfer
        send(1'b1, 32'h20,  32'hA5A55A5A, 8'd1,  1'b1, 1'b0);
        send(1'b0, 32'h20,  32'h0,        8'd1,  1'b0, 1'b1); wait_done();

        for (int k = 0; k < 8; k++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = (32'($urandom_range(0, 15)) << 2) | (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
            send(r_wr, r_addr, $urandom, 8'($urandom_range(0, 4)), 1'b0, 1'b0);
            wait_done();
        end

        // reset in the middle of ACCESS
        send(1'b0, 32'h18, 32'h0, 8'd255, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_psel",      64'(psel),      64'(0));
        chk("midrst_penable",   64'(penable),   64'(0));
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        sb.delete();
        exp_paddr  = '0;
        exp_pwrite = 1'b0;
        exp_pwdata = '0;
        slave_wait = 8'd0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (25) @(posedge clk);
        #1;
        send(1'b0, 32'h08, 32'h0, 8'd0, 1'b0, 1'b0); wait_done();

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

endmodule
